// File: rtl/pulse_trigger_debounce.sv
// Push-button trigger conditioner: 2-flop synchronizer, stable-time debounce,
// press-edge strobe with re-trigger holdoff, and a wrapping trigger counter.
module pulse_trigger_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLDOFF_CYCLES  = 0,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_key_n,
  input  logic                   i_enable,
  output logic                   o_start,
  output logic                   o_key_pressed,
  output logic                   o_holdoff_active,
  output logic [COUNT_WIDTH-1:0] o_trigger_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HO_LOAD = HW'(HOLDOFF_CYCLES);

  logic                   r_sync1, r_sync2;
  logic [DW-1:0]          r_db_cnt;
  logic                   r_kp;
  logic [HW-1:0]          r_hold_cnt;
  logic                   r_hold_act;
  logic                   r_start;
  logic [COUNT_WIDTH-1:0] r_count;

  logic          w_disagree, w_accept, w_fire;
  logic [HW-1:0] w_hold_nxt;

  // sync_n is active-low, so "disagrees with ~key_pressed" means equal levels
  assign w_disagree = (r_sync2 == r_kp);
  assign w_accept   = w_disagree && (r_db_cnt == DB_LAST);
  // holdoff uses the pre-update counter, so a count of 1 still blocks
  assign w_fire     = w_accept && !r_kp && i_enable && (r_hold_cnt == '0);

  always_comb begin
    w_hold_nxt = r_hold_cnt;
    if (w_fire)                 w_hold_nxt = HO_LOAD;
    else if (r_hold_cnt != '0)  w_hold_nxt = r_hold_cnt - HW'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_db_cnt   <= '0;
      r_kp       <= 1'b0;
      r_hold_cnt <= '0;
      r_hold_act <= 1'b0;
      r_start    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_sync1    <= i_key_n;
      r_sync2    <= r_sync1;
      r_db_cnt   <= (!w_disagree || w_accept) ? '0 : r_db_cnt + DW'(1);
      r_kp       <= r_kp ^ w_accept;
      r_hold_cnt <= w_hold_nxt;
      r_hold_act <= (w_hold_nxt != '0);
      r_start    <= w_fire;
      if (w_fire) r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  assign o_start          = r_start;
  assign o_key_pressed    = r_kp;
  assign o_holdoff_active = r_hold_act;
  assign o_trigger_count  = r_count;

endmodule

// File: tb/tb_pulse_trigger_debounce.sv
// Scoreboard bench: driver pushes per-edge expectations from a history-based
// reference model; a negedge monitor pops and compares against the DUT.
module tb_pulse_trigger_debounce;
  localparam int D  = 4;
  localparam int H  = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, key_n, enable;
  logic          start, key_pressed, holdoff_active;
  logic [CW-1:0] trigger_count;

  pulse_trigger_debounce #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .COUNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_reset(reset), .i_key_n(key_n), .i_enable(enable),
    .o_start(start), .o_key_pressed(key_pressed),
    .o_holdoff_active(holdoff_active), .o_trigger_count(trigger_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            st;
    bit            kp;
    bit            ho;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  exp_t got;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      got = q.pop_front();
      vectors++;
      if (start !== got.st || key_pressed !== got.kp ||
          holdoff_active !== got.ho || trigger_count !== got.cnt) begin
        miscompares++;
        $display("FAIL outputs@%0d: got start=%b kp=%b ho=%b cnt=%0d, want start=%b kp=%b ho=%b cnt=%0d",
                 got.cyc, start, key_pressed, holdoff_active, trigger_count,
                 got.st, got.kp, got.ho, got.cnt);
      end
    end
  end

  // Model: every edge since reset release is indexed t; the raw key sampled
  // at edge t reaches the debouncer two edges later. The level is accepted
  // when the last D synchronized samples since the previous change all
  // differ from the current debounced state.
  bit k_hist[$];
  int t, last_tog, ts, cnt, gcyc;
  bit kp, have_ts;

  function automatic bit s_at(int j);
    return (j < 2) ? 1'b1 : k_hist[j-2];
  endfunction

  task automatic model_reset();
    k_hist.delete();
    t = 0; last_tog = -1; ts = 0; have_ts = 0; cnt = 0; kp = 0;
  endtask

  task automatic step(input bit k, input bit en, input bit rst);
    exp_t e;
    bit   tog, fire;
    @(negedge clk); #1;
    key_n = k; enable = en; reset = rst;
    gcyc++;
    e.cyc = gcyc;
    if (rst) begin
      model_reset();
      e.st = 0; e.kp = 0; e.ho = 0; e.cnt = '0;
    end else begin
      k_hist.push_back(k);
      tog = (t - last_tog >= D);
      for (int j = t - D + 1; j <= t; j++)
        if (j < 0 || s_at(j) != kp) tog = 0;
      fire = tog && !kp && en && (!have_ts || (t - ts > H));
      if (tog) begin kp = ~kp; last_tog = t; end
      if (fire) begin ts = t; have_ts = 1; cnt++; end
      e.st  = fire;
      e.kp  = kp;
      e.ho  = have_ts && (t - ts < H);
      e.cnt = cnt[CW-1:0];
      t++;
    end
    q.push_back(e);
  endtask

  task automatic run(input bit k, input bit en, input int n);
    for (int i = 0; i < n; i++) step(k, en, 1'b0);
  endtask

  initial begin
    reset = 1'b1; key_n = 1'b1; enable = 1'b1;
    gcyc = 0;
    model_reset();
    step(1, 1, 1); step(1, 1, 1);
    // clean press: start on edge 5, holdoff edges 5..14
    run(0, 1, 20); run(1, 1, 15);
    // bounce runs of 3 never accepted, then steady press
    for (int r = 0; r < 2; r++) begin run(0, 1, 3); run(1, 1, 3); end
    run(0, 1, 12); run(1, 1, 20);
    // re-press edge 8 cycles after start lands inside holdoff
    run(0, 1, 4); run(1, 1, 4); run(0, 1, 14); run(1, 1, 10);
    run(0, 1, 12); run(1, 1, 12);
    // press while disabled, enable while held, then release and press
    run(0, 0, 10); run(0, 1, 10); run(1, 1, 10); run(0, 1, 12); run(1, 1, 12);
    // 16 spaced presses wrap the 4-bit counter
    for (int r = 0; r < 16; r++) begin run(0, 1, 10); run(1, 1, 12); end
    // reset during debounce, then again mid-holdoff with key held
    run(0, 1, 2); step(0, 1, 1); step(0, 1, 1);
    run(0, 1, 8); step(0, 1, 1); step(0, 1, 1);
    run(0, 1, 12); run(1, 1, 12);
    // randomized runs of key level, enable and occasional reset
    for (int r = 0; r < 120; r++) begin
      bit rk, ren;
      int len;
      rk  = 1'($urandom_range(0, 1));
      ren = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 40) == 0) step(rk, ren, 1);
      run(rk, ren, len);
    end
    run(1, 1, 20);
    @(negedge clk); @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_trigger_debounce.md
Name: pulse_trigger_debounce

Overview:
- Upstream trigger stage for pulse_generator. Conditions a raw, bouncing, active-low board push-button (DE10-Nano KEY).
- Produces the single-cycle `start` strobe that launches a pulse_generator burst.
- Contains a two-flop synchronizer, a stable-time debouncer, press-edge detection and a re-trigger holdoff window.
- A wrapping trigger counter is provided for status/LED debug.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a changed level must hold before acceptance (20 ms at 50 MHz); legal range ≥1.
- HOLDOFF_CYCLES, 0, cycles after a `start` during which new presses are discarded; 0 = no holdoff.
- COUNT_WIDTH, 16, width of trigger_count.

Ports:
- clk  input  1  system clock, 50 MHz, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- key_n  input  1  raw push-button, active-low, asynchronous to clk, may bounce
- enable  input  1  trigger gating; 0 = presses debounced but never produce start
- start  output  1  one-cycle strobe to pulse_generator.start on accepted press
- key_pressed  output  1  debounced button state, 1 = held
- holdoff_active  output  1  1 while holdoff window is running
- trigger_count  output  COUNT_WIDTH  number of start strobes issued, wraps

Behaviour:
- Reset: one clock, asynchronous, active-high. Reset asserted forces:
  - both synchronizer flops = 1 (released)
  - debounce counter = 0, holdoff counter = 0
  - start = 0, key_pressed = 0, holdoff_active = 0, trigger_count = 0
- Reset mid-operation: abandons any debounce in progress or holdoff window.
- Key held through reset release: seen as a new press, produces start after the normal debounce latency.
- Synchronizer: key_n → ff1 → ff2. `sync_n` = ff2. No other logic touches raw key_n.
- Debounce counter:
  - Increments each cycle that sync_n disagrees with ~key_pressed.
  - Clears to 0 on any cycle they agree, so a bounce restarts the count.
  - When the counter = DEBOUNCE_CYCLES-1 and disagreement persists: key_pressed toggles and the counter clears, both on that edge.
  - Counter width = $clog2(DEBOUNCE_CYCLES+1).
- Press edge = key_pressed going 0→1. Release (1→0) never produces start.
- start: registered. High for exactly the cycle in which key_pressed first reads 1, provided all of:
  - enable = 1 at that edge
  - holdoff counter = 0 at that edge
- Latency: raw key_n clean low, first sampled low at edge 0 → key_pressed and start rise on edge DEBOUNCE_CYCLES+1.
- Holdoff:
  - On the edge start is set, holdoff counter loads HOLDOFF_CYCLES.
  - The counter then decrements by 1 per cycle to 0.
  - holdoff_active = (counter ≠ 0), registered with the counter.
  - HOLDOFF_CYCLES = 0 → never active.
  - Holdoff runs regardless of key level or enable.
- Dropped presses: a press edge with enable = 0 or holdoff active is discarded, not queued; no start.
  - Holding the key does not re-trigger when enable rises or holdoff expires. The key must be released (debounced) and pressed again.
- trigger_count: +1 on every cycle start = 1, modulo 2^COUNT_WIDTH (0xFFFF → 0x0000 at default).
- Simultaneous press edge and holdoff reaching 0 on the same edge: the edge uses the pre-update counter value. Counter = 1 → still active → press dropped.
- Max start rate is bounded by the debounce time plus the holdoff window. start is never high on two consecutive cycles.

Test Plan (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=10, COUNT_WIDTH=4):
- Reset, enable=1, key_n low clean at edge 0, held 20 cycles → key_pressed=1 and start=1 on edge 5 only; trigger_count=1; holdoff_active high edges 5–14.
- key_n bounces low-high-low-high with runs of 3 cycles, then steady low → no key_pressed change during bounce; start exactly 5 edges after final steady low sample.
- Press accepted, release and re-press debounced with press edge at 8 cycles after first start → no start (holdoff); re-press after holdoff_active=0 → start, count=2.
- enable=0 during press edge, then enable=1 while key still held → no start, count unchanged; release and press → start.
- 16 clean press/release cycles spaced >20 cycles → trigger_count wraps to 0 after the 16th start; each start exactly one cycle wide.
- Assert reset 2 cycles into debounce and again mid-holdoff with key held → outputs all 0 immediately; after release, held key yields start on edge 5 after reset deasserts (counting first sampled edge as 0).
